uart_rx_fifo: RTL and testbench

- Byte buffer between uart_receiver (producer) and uart_transmitter (consumer) in the UART echo path.
- Absorbs received bytes while the transmitter is busy, so back-to-back received characters are not lost.
- Runs entirely in the 1.84 MHz UART sampling clock domain.
- Reports fill level, and latches a sticky overflow flag when a byte arrives while the buffer is full.

---
 rtl/uart_rx_fifo_if.sv | 22 ++
 rtl/uart_rx_fifo.sv | 71 +++++++
 tb/tb_uart_rx_fifo.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_receiver, the RX byte FIFO and uart_transmitter.
// slave is the FIFO side; master is the producer/consumer side.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO absorbing received UART characters while the transmitter is busy.
// Wrap-bit pointers give full/empty/count; sticky overflow marks a dropped byte.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  uart_samplig_clk,
  input  logic                  reset,
  input  logic                  clear,
  uart_rx_fifo_if.slave         bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] PTR_INC = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_INC;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_INC;
      // Receiver ignores backpressure: a byte offered while full is lost.
      if (bus.in_valid && full) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge uart_samplig_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge uart_samplig_clk) begin
    if (push && !clear) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.in_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model predicts
// contents and flags; a negedge monitor compares the DUT against it.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [AW:0]   count;
  logic          full, empty, overflow;

  uart_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .uart_samplig_clk (clk),
    .reset            (rst_n),
    .clear            (clear),
    .bus              (bus),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: expected byte stream, occupancy and sticky overflow.
  logic [DW-1:0] sb_q[$];
  int            occ = 0;
  bit            ovf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_flush();
    sb_q.delete();
    occ = 0;
    ovf = 1'b0;
  endtask

  // Apply one cycle of stimulus, then advance the model by the rules of the FIFO.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
    int pre;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    clear         = c;
    @(posedge clk);
    if (rst_n) begin
      if (c) model_flush();
      else begin
        pre = occ;
        if (r && pre > 0) occ--;
        if (v) begin
          if (pre < DEPTH) begin
            sb_q.push_back(d);
            occ++;
          end else ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("count",     int'(count),         occ);
      chk("full",      int'(full),          int'(occ == DEPTH));
      chk("empty",     int'(empty),         int'(occ == 0));
      chk("in_ready",  int'(bus.in_ready),  int'(occ != DEPTH));
      chk("out_valid", int'(bus.out_valid), int'(occ != 0));
      chk("overflow",  int'(overflow),      int'(ovf));
      if (occ > 0 && sb_q.size() > 0) begin
        chk("out_data", int'(bus.out_data), int'(sb_q[0]));
        if (bus.out_ready && !clear) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    model_flush();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_count",     int'(count),         0);
    chk("rst_empty",     int'(empty),         1);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_overflow",  int'(overflow),      0);
    idle(2);

    foreach (hello[i]) cyc(1'b1, hello[i], 1'b0, 1'b0);
    drain(6);

    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(1);
    drain(17);
    idle(2);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    idle(1);
    drain(13);

    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    drain(4);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    drain(16);
    cyc(1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    model_flush();
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    idle(1);
    drain(2);

    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)),
          ($urandom_range(0, 199) == 0));
    end
    drain(DEPTH + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
